// File: rtl/i2s_rx_if.sv
// Output-side stream bundle for i2s_rx: stereo frame, valid and ready.
// master drives data/valid and samples ready; slave is the consumer.
interface i2s_rx_if #(
  parameter int W = 16
);
  logic [2*W-1:0] data;
  logic           valid;
  logic           ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/i2s_rx.sv
// Philips I2S receiver: synchronizes bit clock, WS and data into MasterCLK,
// assembles left/right words into stereo frames and buffers them.
// Ports: MasterCLK, Reset (sync, active-high); I2S_CLK/I2S_WS/I2S_DATA in;
// OutputData/OutputValid/OutputReady frame stream; Overflow (sticky),
// OverflowClear; Level = buffered frame count.
// Optional macro I2S_RX_FIFO_EN: 4-entry frame FIFO instead of 1 register.
module i2s_rx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      MasterCLK,
  input  logic                      Reset,
  input  logic                      I2S_CLK,
  input  logic                      I2S_WS,
  input  logic                      I2S_DATA,
  output logic [2*SAMPLE_WIDTH-1:0] OutputData,
  output logic                      OutputValid,
  input  logic                      OutputReady,
  output logic                      Overflow,
  input  logic                      OverflowClear,
  output logic [2:0]                Level
);

`ifdef I2S_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam int IW = $clog2(SAMPLE_WIDTH);
  localparam int FW = 2 * SAMPLE_WIDTH;

  typedef enum logic [1:0] {
    UNSYNC    = 2'd0,
    WAIT_LEFT = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
  logic sck_s, ws_s, sd_s, sck_d;
  logic strobe, ws_chg;
  logic have_prev, ws_prev;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [SAMPLE_WIDTH-1:0] sh, word_next, left_hold;
  logic [FW-1:0] frame_q;
  logic push_q;

  logic [FW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic pop, full, wr, ovf;

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign ws_s  = ws_sync[SYNC_STAGES-1];
  assign sd_s  = sd_sync[SYNC_STAGES-1];

  assign strobe = sck_s & ~sck_d;
  // The very first strobe has no reference WS, so it cannot be a change.
  assign ws_chg = strobe & have_prev & (ws_s != ws_prev);

  // Bits land MSB-first at their final position, so short words end up
  // left-justified with zero LSBs and long words simply stop filling.
  always_comb begin
    word_next = sh;
    idx = IW'(SAMPLE_WIDTH - 1) - cnt[IW-1:0];
    if (cnt < CW'(SAMPLE_WIDTH))
      word_next[idx] = sd_s;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      UNSYNC:    if (ws_chg) state_d = WAIT_LEFT;
      WAIT_LEFT: if (ws_chg && !ws_prev) state_d = RUN;
      RUN:       state_d = RUN;
      default:   state_d = UNSYNC;
    endcase
  end

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      state     <= UNSYNC;
      sck_sync  <= '0;
      ws_sync   <= '0;
      sd_sync   <= '0;
      sck_d     <= 1'b0;
      have_prev <= 1'b0;
      ws_prev   <= 1'b0;
      cnt       <= '0;
      sh        <= '0;
      left_hold <= '0;
      frame_q   <= '0;
      push_q    <= 1'b0;
    end else begin
      state    <= state_d;
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], I2S_CLK};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], I2S_WS};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], I2S_DATA};
      sck_d    <= sck_s;
      push_q   <= 1'b0;
      if (strobe) begin
        have_prev <= 1'b1;
        ws_prev   <= ws_s;
        if (ws_chg) begin
          // This strobe carried the LSB of the word for ws_prev.
          sh  <= '0;
          cnt <= '0;
          if (!ws_prev) begin
            left_hold <= word_next;
          end else if (state == RUN) begin
            frame_q <= {left_hold, word_next};
            push_q  <= 1'b1;
          end
        end else begin
          sh <= word_next;
          if (cnt < CW'(SAMPLE_WIDTH))
            cnt <= cnt + 1'b1;
        end
      end
    end
  end

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop  = OutputValid & OutputReady;
  assign full = (count == 3'(DEPTH));
  // A pop on a full buffer frees the slot the same-cycle push lands in.
  assign wr   = push_q & (~full | pop);
  assign ovf  = push_q & full & ~pop;

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= frame_q;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop)
        rd_ptr <= nxt(rd_ptr);
      count <= count + 3'(wr) - 3'(pop);
      if (ovf)
        Overflow <= 1'b1;
      else if (OverflowClear)
        Overflow <= 1'b0;
    end
  end

  assign OutputValid = (count != 3'd0);
  assign OutputData  = OutputValid ? mem[rd_ptr] : '0;
  assign Level       = count;

endmodule
